// File: rtl/div_pkg.sv
// ============================================================================
//  Module      : div_pkg
//  Description : Shared defaults, FSM state type and counter sizing for the
//                sequential restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DIVIDEND_W_DEF = 32;
    localparam int DIVISOR_W_DEF  = 16;

    // Iteration counter must be able to hold the value DIVIDEND_W itself
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W_DEF = $clog2(DIVIDEND_W_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
//  Module      : div_step
//  Description : One combinational radix-2 restoring division iteration.
//                Shifts the partial remainder left, brings in the next
//                dividend bit and subtracts the divisor when it fits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int DIVISOR_W = 16
) (
    input  logic [DIVISOR_W:0]   i_prem,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W:0]   o_prem,
    output logic                 o_qbit
);

    logic [DIVISOR_W+1:0] w_shift;
    logic [DIVISOR_W:0]   w_diff;
    logic                 w_take;

    // Compare on the full shifted value so a zero divisor (where the partial
    // remainder can grow into its top bit) still behaves consistently.
    always_comb begin
        w_shift = {i_prem, i_bit};
        w_take  = (w_shift >= {2'b00, i_divisor});
        w_diff  = w_shift[DIVISOR_W:0] - {1'b0, i_divisor};
        o_qbit  = w_take;
        o_prem  = w_take ? w_diff : w_shift[DIVISOR_W:0];
    end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
//  Module      : seq_divider
//  Description : Sequential unsigned restoring divider, one quotient bit per
//                clock. IDLE -> RUN (DIVIDEND_W steps) -> DONE -> IDLE.
//                Optional macro SEQ_DIVIDER_DIVZERO_EN: a zero divisor is
//                short-circuited to DONE and flagged on div_by_zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  done,
    output logic                  busy,
    output logic                  div_by_zero
);

    localparam int CNT_W = cnt_width(DIVIDEND_W);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DIVIDEND_W);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DIVIDEND_W-1:0]   r_dvd;      // dividend shifting out, quotient shifting in
    logic [DIVISOR_W-1:0]    r_dvs;
    logic [DIVISOR_W:0]      r_prem;
    logic [CNT_W-1:0]        r_cnt;
    logic [DIVIDEND_W-1:0]   r_quot;
    logic [DIVISOR_W-1:0]    r_rem;
    logic                    r_dbz;
    logic [DIVISOR_W:0]      w_prem_next;
    logic                    w_qbit;
    logic                    w_zero_dvs;

    assign w_zero_dvs = (r_dvs == '0);

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .i_prem    (r_prem),
        .i_bit     (r_dvd[DIVIDEND_W-1]),
        .i_divisor (r_dvs),
        .o_prem    (w_prem_next),
        .o_qbit    (w_qbit)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; RUN steps while the counter is below DIVIDEND_W and
    // leaves on the cycle the counter reaches it, so results come from registers
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN: begin
`ifdef SEQ_DIVIDER_DIVZERO_EN
                if (w_zero_dvs) w_state_next = ST_DONE;
                else
`endif
                if (r_cnt == c_LAST) w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        done = 1'b0;
        busy = 1'b0;
        case (r_state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, iteration, and result latch on DONE entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_prem <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dvd  <= dividend;
                        r_dvs  <= divisor;
                        r_prem <= '0;
                        r_cnt  <= '0;
                    end
                end
                ST_RUN: begin
`ifdef SEQ_DIVIDER_DIVZERO_EN
                    if (w_zero_dvs) begin
                        r_quot <= '1;
                        r_rem  <= r_dvd[DIVISOR_W-1:0];
                        r_dbz  <= 1'b1;
                    end else
`endif
                    if (r_cnt == c_LAST) begin
                        r_quot <= r_dvd;
                        r_rem  <= r_prem[DIVISOR_W-1:0];
                        r_dbz  <= 1'b0;
                    end else begin
                        r_dvd  <= {r_dvd[DIVIDEND_W-2:0], w_qbit};
                        r_prem <= w_prem_next;
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;

`ifdef SEQ_DIVIDER_DIVZERO_EN
    assign div_by_zero = r_dbz;
`else
    // Flag register is kept for reset symmetry but never reaches the port
    assign div_by_zero = 1'b0 & r_dbz;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Directed self-checking bench for seq_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        done;
    logic        busy;
    logic        div_by_zero;

    int n_vec;
    int n_mis;

    seq_divider #(
        .DIVIDEND_W (32),
        .DIVISOR_W  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands in the middle of a cycle; they are taken on the next edge (E0)
    task automatic start_op(input logic [31:0] a, input logic [15:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after E0 until done is seen; -1 if it never arrives
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_case(input string tag, input logic [31:0] a, input logic [15:0] b,
                            input logic [31:0] eq, input logic [15:0] er,
                            input int elat, input logic edz);
        int lat;
        start_op(a, b);
        check_val({tag, "_busy"}, 64'(busy), 64'(1));
        wait_done(lat);
        check_val({tag, "_lat"}, 64'(lat), 64'(elat));
        check_val({tag, "_q"}, 64'(quotient), 64'(eq));
        check_val({tag, "_r"}, 64'(remainder), 64'(er));
        check_val({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
        @(posedge clk);
        #1;
        check_val({tag, "_pulse"}, 64'(done), 64'(0));
        check_val({tag, "_idle"}, 64'(busy), 64'(0));
        check_val({tag, "_hold_q"}, 64'(quotient), 64'(eq));
    endtask

    logic [31:0] tv_a [7];
    logic [15:0] tv_b [7];
    logic [31:0] tv_q [7];
    logic [15:0] tv_r [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int ndone;
        n_vec    = 0;
        n_mis    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        tv_a[0] = 32'd12;         tv_b[0] = 16'd4;     tv_q[0] = 32'd3;          tv_r[0] = 16'd0;
        tv_a[1] = 32'd56088;      tv_b[1] = 16'd456;   tv_q[1] = 32'd123;        tv_r[1] = 16'd0;
        tv_a[2] = 32'd1046529;    tv_b[2] = 16'd1023;  tv_q[2] = 32'd1023;       tv_r[2] = 16'd0;
        tv_a[3] = 32'd60001;      tv_b[3] = 16'd2;     tv_q[3] = 32'd30000;      tv_r[3] = 16'd1;
        tv_a[4] = 32'hFFFFFFFF;   tv_b[4] = 16'd1;     tv_q[4] = 32'hFFFFFFFF;   tv_r[4] = 16'd0;
        tv_a[5] = 32'd5;          tv_b[5] = 16'd65535; tv_q[5] = 32'd0;          tv_r[5] = 16'd5;
        tv_a[6] = 32'd0;          tv_b[6] = 16'd7;     tv_q[6] = 32'd0;          tv_r[6] = 16'd0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_q", 64'(quotient), 64'(0));
        check_val("rst_r", 64'(remainder), 64'(0));
        check_val("rst_done", 64'(done), 64'(0));
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_dz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_case($sformatf("vec%0d", i), tv_a[i], tv_b[i], tv_q[i], tv_r[i], 33, 1'b0);
        end

`ifdef SEQ_DIVIDER_DIVZERO_EN
        run_case("divzero", 32'd100, 16'd0, 32'hFFFFFFFF, 16'd100, 1, 1'b1);
`else
        run_case("divzero", 32'd100, 16'd0, 32'hFFFFFFFF, 16'd100, 33, 1'b0);
`endif
        // A normal division afterwards must clear the zero-divisor flag
        run_case("after_dz", 32'd12, 16'd4, 32'd3, 16'd0, 33, 1'b0);

        // Start while busy is ignored; a start in the IDLE cycle after DONE is taken
        start_op(32'd200, 16'd10);
        ndone = 0;
        lat   = -1;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #1;
            if (k == 9) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 16'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                lat = k;
            end
        end
        check_val("busy_ndone", 64'(ndone), 64'(1));
        check_val("busy_lat", 64'(lat), 64'(33));
        check_val("busy_q", 64'(quotient), 64'(20));
        check_val("busy_r", 64'(remainder), 64'(0));
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("b2b_busy", 64'(busy), 64'(1));
        wait_done(lat);
        check_val("b2b_lat", 64'(lat), 64'(33));
        check_val("b2b_q", 64'(quotient), 64'(3));
        check_val("b2b_r", 64'(remainder), 64'(0));
        @(posedge clk);
        #1;

        // Reset in the middle of an operation abandons it
        start_op(32'd1000, 16'd7);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("mrst_q", 64'(quotient), 64'(0));
        check_val("mrst_r", 64'(remainder), 64'(0));
        check_val("mrst_done", 64'(done), 64'(0));
        check_val("mrst_busy", 64'(busy), 64'(0));
        check_val("mrst_dz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check_val("mrst_nodone", 64'(ndone), 64'(0));
        run_case("post_rst", 32'd1000, 16'd7, 32'd142, 16'd6, 33, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 32: dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_W, default 16: divisor and remainder width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port dividend  input  DIVIDEND_W  unsigned numerator; sampled with accepted start.
REQ-007 SHALL have port divisor  input  DIVISOR_W  unsigned denominator; sampled with accepted start.
REQ-008 SHALL have port quotient  output  DIVIDEND_W  result of dividend / divisor.
REQ-009 SHALL have port remainder  output  DIVISOR_W  result of dividend mod divisor.
REQ-010 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port busy  output  1  high from accepted start until done.
REQ-012 SHALL have port div_by_zero  output  1  error flag, valid with done.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE with start=1 at edge E0 SHALL latch dividend and divisor, clear the iteration counter, set busy, and enter RUN.
REQ-015 RUN SHALL perform one radix-2 restoring step per cycle: shift partial remainder left, bringing in the next dividend MSB; subtract divisor if result >= 0; quotient bit = 1 iff the subtraction was taken.
REQ-016 The partial remainder SHALL be DIVISOR_W+1 bits wide, so the compare never overflows.
REQ-017 RUN SHALL last exactly DIVIDEND_W cycles (edges E1..E32 at default widths) and then enter DONE.
REQ-018 quotient and remainder SHALL update only on entry to DONE.
REQ-019 done SHALL be high for exactly one cycle, the cycle after edge E33 at default widths.
REQ-020 DONE SHALL return to IDLE unconditionally on the next edge, clearing busy.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values until the next DONE or a reset.
REQ-022 start while busy (RUN or DONE) SHALL be ignored, with no effect on the operation in flight.
REQ-023 start in the IDLE cycle directly following DONE SHALL be accepted normally, giving back-to-back operation.
REQ-024 dividend < divisor SHALL yield quotient=0 and remainder=dividend.
REQ-025 divisor=0 SHALL yield quotient=all-ones and remainder=dividend[DIVISOR_W-1:0].

Reset
REQ-026 rst=1 SHALL force, asynchronously: FSM=IDLE, quotient=0, remainder=0, done=0, busy=0, div_by_zero=0, counter=0.
REQ-027 rst asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-028 After rst falls, the first start SHALL be accepted.

Configuration
REQ-029 Macro SEQ_DIVIDER_DIVZERO_EN defined: divisor=0 at start SHALL skip RUN and go IDLE->DONE, so done pulses after edge E1; div_by_zero=1 with done; results per REQ-025.
REQ-030 Macro undefined: divisor=0 SHALL run the full DIVIDEND_W cycles, with results per REQ-025, and div_by_zero SHALL be tied to 0.

Structure
REQ-031 Package div_pkg SHALL hold the DIVIDEND_W/DIVISOR_W defaults, the FSM state enum typedef, and the counter width constant ($clog2(DIVIDEND_W+1)).
REQ-032 Sub-module div_step SHALL implement one combinational restoring iteration (inputs: partial remainder, incoming bit, divisor; outputs: next partial remainder, quotient bit), instantiated once.

Verification
REQ-033 Directed cases: 12/4 -> q=3 r=0; 56088/456 -> q=123 r=0; 1046529/1023 -> q=1023 r=0; 60001/2 -> q=30000 r=1; each with done exactly 33 cycles after the start edge.
REQ-034 Boundary cases: 32'hFFFFFFFF/1 -> q=32'hFFFFFFFF r=0; 5/65535 -> q=0 r=5; 0/7 -> q=0 r=0.
REQ-035 Divide by zero: 100/0 -> q=32'hFFFFFFFF r=100; with macro, done after edge E1 and div_by_zero=1; without macro, done after edge E33 and div_by_zero=0.
REQ-036 Busy protection: 200/10 started, then start pulsed with 9/3 at cycle 10 -> single done with q=20 r=0; a second start in the cycle after done gives 9/3 -> q=3 r=0.
REQ-037 Reset: rst pulsed at cycle 15 of 1000/7 -> no done pulse, all outputs 0; a following 1000/7 -> q=142 r=6.
